// File: rtl/multi_service_unit_pkg.sv
// Shared definitions for the APB event/interrupt service unit: register offsets,
// serve-FSM states and the address decoder.
package service_unit_pkg;

  localparam logic [4:0] OFS_ENABLE   = 5'h00;
  localparam logic [4:0] OFS_PENDING  = 5'h04;
  localparam logic [4:0] OFS_ACK      = 5'h08;
  localparam logic [4:0] OFS_MODE     = 5'h0C;
  localparam logic [4:0] OFS_PEND_SET = 5'h10;
  localparam logic [4:0] OFS_PEND_CLR = 5'h14;
  localparam logic [4:0] OFS_ACK_ID   = 5'h18;

  typedef enum logic [0:0] {
    SU_IDLE  = 1'b0,
    SU_SERVE = 1'b1
  } su_state_t;

  typedef enum logic [2:0] {
    REG_ENABLE,
    REG_PENDING,
    REG_ACK,
    REG_MODE,
    REG_PEND_SET,
    REG_PEND_CLR,
    REG_ACK_ID,
    REG_NONE
  } su_reg_t;

  // Only the word address PADDR[4:2] is decoded.
  function automatic su_reg_t su_decode(input logic [2:0] word);
    logic [4:0] ofs;
    ofs = {word, 2'b00};
    case (ofs)
      OFS_ENABLE:   return REG_ENABLE;
      OFS_PENDING:  return REG_PENDING;
      OFS_ACK:      return REG_ACK;
      OFS_MODE:     return REG_MODE;
      OFS_PEND_SET: return REG_PEND_SET;
      OFS_PEND_CLR: return REG_PEND_CLR;
      OFS_ACK_ID:   return REG_ACK_ID;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multi_service_unit_if.sv
// APB slave bundle of the service unit; master side drives address/data/strobes.
interface multi_service_unit_if #(
  parameter int APB_ADDR_WIDTH = 12
) ();
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/multi_service_unit_prio_onehot_enc.sv
// Combinational priority encoder: one-hot and index of the highest set bit.
module prio_onehot_enc #(
  parameter int NUM_SRC = 32
) (
  input  logic [NUM_SRC-1:0] vec_i,
  output logic [NUM_SRC-1:0] onehot_o,
  output logic [4:0]         idx_o,
  output logic               valid_o
);

  // Ascending scan: the last set bit seen is the highest and wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = 5'(i);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_service_unit.sv
// APB event/interrupt service unit with sticky pending bits and a serve FSM.
// Define SERVICE_UNIT_SYNC_EN to add a 2-flop synchroniser on signal_i.
module multi_service_unit
  import service_unit_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = 32
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  multi_service_unit_if.slave      apb,
  input  logic [NUM_SRC-1:0]       signal_i,
  output logic                     irq_o
);

  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [4:0]         ack_idx_q, ack_idx_d;
  su_state_t          state_q, state_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0]        sig_s;
  logic [NUM_SRC-1:0]        events;
  logic [NUM_SRC-1:0]        load_onehot;
  logic [4:0]                load_idx;
  logic                      load_valid;
  logic                      load;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [NUM_SRC-1:0]        wdata;
  logic                      access, wr_en, rd_en;
  su_reg_t                   sel_reg;
  logic [31:0]               rdata_mux;

`ifdef SERVICE_UNIT_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  assign sync1_d = signal_i;
  assign sync2_d = sync1_q;
  assign sig_s   = sync2_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  assign sig_s = signal_i;
`endif

  assign paddr   = apb.PADDR;
  assign wdata   = apb.PWDATA[NUM_SRC-1:0];
  assign access  = apb.PSEL & apb.PENABLE;
  assign wr_en   = access & apb.PWRITE;
  assign rd_en   = access & ~apb.PWRITE;
  assign sel_reg = su_decode(paddr[4:2]);

  // Edge sources fire only on a 0->1 transition; level sources fire while high.
  assign events = enable_q & sig_s & (~mode_q | ~prev_q);

  prio_onehot_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .vec_i    (pending_q),
    .onehot_o (load_onehot),
    .idx_o    (load_idx),
    .valid_o  (load_valid)
  );

  assign load = (state_q == SU_IDLE) && load_valid;

  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    ack_d     = ack_q;
    ack_idx_d = ack_idx_q;
    state_d   = state_q;
    prev_d    = sig_s;

    if (wr_en) begin
      case (sel_reg)
        REG_ENABLE:   enable_d  = wdata;
        REG_MODE:     mode_d    = wdata;
        REG_PENDING:  pending_d = wdata;
        REG_PEND_SET: pending_d = pending_d | wdata;
        REG_PEND_CLR: pending_d = pending_d & ~wdata;
        default: ;
      endcase
    end

    if (load) begin
      pending_d = pending_d & ~load_onehot;
      ack_d     = load_onehot;
      ack_idx_d = load_idx;
      state_d   = SU_SERVE;
    end else if ((state_q == SU_SERVE) && rd_en && (sel_reg == REG_ACK)) begin
      ack_d   = '0;
      state_d = SU_IDLE;
    end

    // New events are merged last so a same-cycle software clear cannot drop them.
    pending_d = pending_d | events;
    irq_d     = (state_d == SU_SERVE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      ack_q     <= '0;
      ack_idx_q <= '0;
      prev_q    <= '0;
      state_q   <= SU_IDLE;
      irq_q     <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      ack_idx_q <= ack_idx_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (sel_reg)
      REG_ENABLE:  rdata_mux[NUM_SRC-1:0] = enable_q;
      REG_PENDING: rdata_mux[NUM_SRC-1:0] = pending_q;
      REG_ACK:     rdata_mux[NUM_SRC-1:0] = ack_q;
      REG_MODE:    rdata_mux[NUM_SRC-1:0] = mode_q;
      REG_ACK_ID:  if (ack_q != '0) rdata_mux = {1'b1, 26'b0, ack_idx_q};
      default: ;
    endcase
  end

  assign apb.PRDATA  = rd_en ? rdata_mux : 32'h0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & (sel_reg == REG_NONE);
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_multi_service_unit.sv
// Self-checking bench for multi_service_unit: directed scenarios plus random APB/event
// traffic against a transaction-level reference model (honours SERVICE_UNIT_SYNC_EN).
module tb_multi_service_unit;

`ifdef SERVICE_UNIT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] sig;
  logic        irq;
  logic [7:0]  sig8;
  logic        irq8;

  multi_service_unit_if #(.APB_ADDR_WIDTH(12)) bus ();
  multi_service_unit_if #(.APB_ADDR_WIDTH(12)) bus8 ();

  multi_service_unit #(.APB_ADDR_WIDTH(12), .NUM_SRC(32)) dut (
    .HCLK     (clk),
    .HRESETn  (rst_n),
    .apb      (bus),
    .signal_i (sig),
    .irq_o    (irq)
  );

  multi_service_unit #(.APB_ADDR_WIDTH(12), .NUM_SRC(8)) dut8 (
    .HCLK     (clk),
    .HRESETn  (rst_n),
    .apb      (bus8),
    .signal_i (sig8),
    .irq_o    (irq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit done8  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- reference model (register/transaction level) ----------------
  bit [31:0] m_en, m_mode, m_pend, m_ack, m_prev, m_s1, m_s2;
  int        m_idx;
  bit        m_irq;

  task automatic m_reset();
    m_en = 0; m_mode = 0; m_pend = 0; m_ack = 0; m_prev = 0;
    m_s1 = 0; m_s2 = 0; m_idx = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] m_read(input int w);
    case (w)
      0: return m_en;
      1: return m_pend;
      2: return m_ack;
      3: return m_mode;
      6: return (m_ack != 0) ? (32'h8000_0000 | 32'(m_idx)) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step(input bit acc, input bit wr, input int w, input bit [31:0] wd,
                        input bit [31:0] sig_in);
    bit [31:0] s, ev, p;
    int top;
`ifdef SERVICE_UNIT_SYNC_EN
    s = m_s2;
`else
    s = sig_in;
`endif
    ev = 0;
    for (int i = 0; i < 32; i++)
      if (m_en[i] && s[i] && (!m_mode[i] || !m_prev[i])) ev[i] = 1'b1;
    p = m_pend;
    if (acc && wr) begin
      if (w == 1) p = wd;
      if (w == 4) p = p | wd;
      if (w == 5) p = p & ~wd;
    end
    if (m_ack == 0 && m_pend != 0) begin
      top = 0;
      for (int i = 31; i >= 0; i--) if (m_pend[i]) begin top = i; break; end
      p[top] = 1'b0;
      m_ack  = 32'd1 << top;
      m_idx  = top;
    end else if (m_ack != 0 && acc && !wr && w == 2) begin
      m_ack = 0;
    end
    m_pend = p | ev;
    if (acc && wr && w == 0) m_en   = wd;
    if (acc && wr && w == 3) m_mode = wd;
    m_s2   = m_s1;
    m_s1   = sig_in;
    m_prev = s;
    m_irq  = (m_ack != 0);
  endtask

  // ---------------- cycle driver: every call starts and ends at a negedge ----------------
  logic [31:0] sig_drv;

  task automatic tick(input bit sel, input bit en, input bit wr, input int w,
                      input logic [31:0] wd, output logic [31:0] rd);
    bus.PSEL    = sel;
    bus.PENABLE = en;
    bus.PWRITE  = wr;
    bus.PADDR   = 12'(w * 4);
    bus.PWDATA  = wd;
    sig         = sig_drv;
    #1;
    rd = bus.PRDATA;
    if (sel && en && !wr) chk($sformatf("prdata@%0h", w * 4), bus.PRDATA, m_read(w));
    else                  chk("prdata_idle", bus.PRDATA, 32'h0);
    chk("pslverr", {31'b0, bus.PSLVERR}, {31'b0, (sel && en && w == 7)});
    @(posedge clk);
    m_step(sel && en, wr, w, wd, sig_drv);
    @(negedge clk);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 32'h0, d);
  endtask

  task automatic apb_wr(input int w, input logic [31:0] wd);
    logic [31:0] d;
    tick(1'b1, 1'b0, 1'b1, w, wd, d);
    tick(1'b1, 1'b1, 1'b1, w, wd, d);
    $display("apb wr ofs=0x%02h data=0x%08h", w * 4, wd);
  endtask

  task automatic apb_rd(input int w, output logic [31:0] rd);
    logic [31:0] d;
    tick(1'b1, 1'b0, 1'b0, w, 32'h0, d);
    tick(1'b1, 1'b1, 1'b0, w, 32'h0, rd);
    $display("apb rd ofs=0x%02h data=0x%08h", w * 4, rd);
  endtask

  // ---------------- NUM_SRC=8 instance: upper register bits read 0 ----------------
  task automatic b8_xfer(input bit wr, input int w, input logic [31:0] wd, output logic [31:0] rd);
    bus8.PSEL = 1'b1; bus8.PENABLE = 1'b0; bus8.PWRITE = wr;
    bus8.PADDR = 12'(w * 4); bus8.PWDATA = wd;
    @(negedge clk);
    bus8.PENABLE = 1'b1;
    #1 rd = bus8.PRDATA;
    @(negedge clk);
    bus8.PSEL = 1'b0; bus8.PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    bus8.PSEL = 0; bus8.PENABLE = 0; bus8.PWRITE = 0; bus8.PADDR = 0; bus8.PWDATA = 0;
    sig8 = 8'h0;
    @(posedge rst_n);
    @(negedge clk);
    b8_xfer(1'b1, 0, 32'hFFFF_FFFF, d);
    b8_xfer(1'b0, 0, 32'h0, d);
    chk("n8_enable", d, 32'h0000_00FF);
    b8_xfer(1'b1, 3, 32'hA5A5_A5A5, d);
    b8_xfer(1'b0, 3, 32'h0, d);
    chk("n8_mode", d, 32'h0000_00A5);
    chk("n8_irq", {31'b0, irq8}, 32'h0);
    done8 = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    int          op, guard;
    rst_n = 1'b0;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    sig = 0; sig_drv = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_pready", {31'b0, bus.PREADY}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 7; w++) begin
      apb_rd(w, d);
      chk("rst_reg", d, 32'h0);
    end

    // 1: edge pulse on bit 2
    apb_wr(0, 32'h5);
    apb_wr(3, 32'h5);
    sig_drv = 32'h4; idle(1); sig_drv = 0;
    idle(1 + SL);
    chk("t1_irq_hi", {31'b0, irq}, 32'h1);
    apb_rd(6, d); chk("t1_ack_id", d, 32'h8000_0002);
    apb_rd(2, d); chk("t1_ack", d, 32'h4);
    idle(1);
    chk("t1_irq_lo", {31'b0, irq}, 32'h0);

    // 2: simultaneous edges on bits 3 and 17, highest served first
    apb_wr(0, 32'hFFFF_FFFF);
    apb_wr(3, 32'hFFFF_FFFF);
    sig_drv = 32'h0002_0008; idle(1); sig_drv = 0;
    idle(1 + SL);
    apb_rd(2, d); chk("t2_ack_first", d, 32'h0002_0000);
    idle(1);
    apb_rd(2, d); chk("t2_ack_second", d, 32'h8);

    // 3: level source re-pends while held
    apb_wr(0, 32'h1);
    apb_wr(3, 32'h0);
    sig_drv = 32'h1;
    idle(2 + SL);
    apb_rd(2, d); chk("t3_ack_lvl", d, 32'h1);
    idle(1);
    sig_drv = 0;
    for (int r = 0; r < 3; r++) begin idle(3); apb_rd(2, d); end
    idle(3);
    apb_rd(2, d); chk("t3_ack_empty", d, 32'h0);
    apb_rd(1, d); chk("t3_pend_empty", d, 32'h0);

    // 4: clear vs same-cycle event; software set with sources disabled
    apb_wr(0, 32'h10);
    apb_wr(3, 32'h10);
    tick(1'b1, 1'b0, 1'b1, 5, 32'h10, d);
    sig_drv = 32'h10;
    tick(1'b1, 1'b1, 1'b1, 5, 32'h10, d);
    sig_drv = 0;
    idle(1 + SL);
    apb_rd(2, d); chk("t4_ack_ev", d, 32'h10);
    apb_wr(0, 32'h0);
    apb_wr(4, 32'h100);
    idle(1);
    chk("t4_irq", {31'b0, irq}, 32'h1);
    apb_rd(2, d); chk("t4_ack_set", d, 32'h100);

    // 5: unmapped offset, ignored writes to read-only registers
    apb_rd(7, d); chk("t5_unmapped", d, 32'h0);
    apb_wr(7, 32'hDEAD_BEEF);
    apb_wr(2, 32'hFFFF_FFFF);
    apb_wr(6, 32'hFFFF_FFFF);
    apb_rd(2, d); chk("t5_ack_ro", d, 32'h0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      sig_drv = $urandom & $urandom & $urandom;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: idle($urandom_range(1, 3));
        3, 4, 5: apb_rd(2, d);
        6:       apb_rd($urandom_range(0, 7), d);
        7:       apb_wr($urandom_range(0, 5), $urandom);
        8:       apb_wr((($urandom & 1) != 0) ? 6 : 2, $urandom);
        default: apb_wr(3, $urandom);
      endcase
    end
    sig_drv = 0;

    // 6: asynchronous reset while serving
    apb_wr(4, 32'h1);
    idle(2);
    chk("t6_serving", {31'b0, irq}, 32'h1);
    #2;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 12'h004;
    rst_n = 1'b0;
    #1;
    chk("t6_irq_async", {31'b0, irq}, 32'h0);
    chk("t6_pend_async", bus.PRDATA, 32'h0);
    bus.PADDR = 12'h008;
    #1;
    chk("t6_ack_async", bus.PRDATA, 32'h0);
    m_reset();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apb_rd(1, d); chk("t6_pend_after", d, 32'h0);
    apb_rd(0, d); chk("t6_en_after", d, 32'h0);

    guard = 0;
    while (!done8 && guard < 1000) begin @(negedge clk); guard++; end
    chk("n8_done", {31'b0, done8}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
